// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared state encoding for the button event channels
package btn_pkg;

  localparam int BTN_STATE_W = 2;

  typedef enum logic [BTN_STATE_W-1:0] {
    BTN_IDLE     = 2'd0,
    BTN_PRESSED  = 2'd1,
    BTN_HELD     = 2'd2,
    BTN_RELEASED = 2'd3
  } btn_state_t;

endpackage

// File: rtl/btn_channel.sv
// rtl/btn_channel.sv - one button: synchroniser, debouncer, event FSM, auto-repeat
// Auto-repeat is built only when BTN_AUTOREPEAT_EN is defined.
import btn_pkg::*;

module btn_channel #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       held,
  output logic       repeat_pulse,
  output btn_state_t state
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LIMIT = CW'(DEBOUNCE_CYCLES);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
  end

  logic          raw_in;
  logic [1:0]    sync;
  logic          deb;
  logic [CW-1:0] cnt;
  btn_state_t    state_q;
  btn_state_t    state_d;

  // Polarity is folded in ahead of the synchroniser so everything after sees 1 = pressed.
  assign raw_in = (ACTIVE_LOW != 0) ? ~raw : raw;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], raw_in};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      deb <= 1'b0;
      cnt <= '0;
    end else if (sync[1] == deb) begin
      cnt <= '0;
    end else if (cnt == CNT_LIMIT) begin
      deb <= ~deb;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BTN_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BTN_IDLE:     if (deb) state_d = BTN_PRESSED;
      BTN_PRESSED:  state_d = BTN_HELD;
      BTN_HELD:     if (!deb) state_d = BTN_RELEASED;
      BTN_RELEASED: state_d = BTN_IDLE;
      default:      state_d = BTN_IDLE;
    endcase
  end

  assign press_pulse   = (state_q == BTN_PRESSED);
  assign release_pulse = (state_q == BTN_RELEASED);
  assign held          = (state_q == BTN_PRESSED) || (state_q == BTN_HELD);
  assign state         = state_q;

`ifdef BTN_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rcnt;
  logic          first;
  logic          rep_hit;

  // rcnt holds (cycles spent in HELD since the last pulse) - 1; first selects the initial delay.
  assign rep_hit = (state_q == BTN_HELD) && (rcnt == (first ? DELAY_LAST : PERIOD_LAST));

  always_ff @(posedge clk) begin
    if (reset || state_q != BTN_HELD) begin
      rcnt  <= '0;
      first <= 1'b1;
    end else if (rep_hit) begin
      rcnt  <= '0;
      first <= 1'b0;
    end else begin
      rcnt <= rcnt + 1'b1;
    end
  end

  assign repeat_pulse = rep_hit;
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/button_events.sv
// rtl/button_events.sv - multi-channel debounced button event generator
// Auto-repeat pulses are enabled by defining BTN_AUTOREPEAT_EN.
import btn_pkg::*;

module button_events #(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic [NUM_BTN-1:0]     btn_raw,
  output logic [NUM_BTN-1:0]     press_pulse,
  output logic [NUM_BTN-1:0]     release_pulse,
  output logic [NUM_BTN-1:0]     held,
  output logic [NUM_BTN-1:0]     repeat_pulse,
  output logic [2*NUM_BTN-1:0]   btn_state
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_state_t st;

    btn_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_ch (
      .clk           (CLOCK_50),
      .reset         (reset),
      .raw           (btn_raw[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .held          (held[i]),
      .repeat_pulse  (repeat_pulse[i]),
      .state         (st)
    );

    assign btn_state[BTN_STATE_W*i +: BTN_STATE_W] = st;
  end

endmodule

// File: tb/tb_button_events.sv
// tb/tb_button_events.sv - scoreboard bench for button_events (NUM_BTN=2, DEBOUNCE_CYCLES=4)
module tb_button_events;

  localparam int NB  = 2;
  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;
  localparam int LAT = DEB + 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] press_pulse;
  logic [NB-1:0] release_pulse;
  logic [NB-1:0] held;
  logic [NB-1:0] repeat_pulse;
  logic [2*NB-1:0] btn_state;

  button_events #(
    .NUM_BTN         (NB),
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP),
    .ACTIVE_LOW      (1)
  ) dut (
    .CLOCK_50      (clk),
    .reset         (reset),
    .btn_raw       (btn_raw),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .held          (held),
    .repeat_pulse  (repeat_pulse),
    .btn_state     (btn_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    int         kind;
    logic [1:0] mask;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   mon_en   = 1'b0;

  function automatic string kname(int kd);
    case (kd)
      0:       return "press_pulse";
      1:       return "release_pulse";
      default: return "repeat_pulse";
    endcase
  endfunction

  task automatic push(input int c, input int kd, input logic [1:0] m);
    exp_t e;
    e.cyc  = c;
    e.kind = kd;
    e.mask = m;
    exp_q.push_back(e);
  endtask

  // Pulses are tagged with the number of the edge that started the cycle they are seen in.
  logic [1:0] obs [3];
  int         idx;
  always @(negedge clk) begin
    if (mon_en) begin
      obs[0] = press_pulse;
      obs[1] = release_pulse;
      obs[2] = repeat_pulse;
      for (int kd = 0; kd < 3; kd++) begin
        if (obs[kd] !== 2'b00) begin
          idx = -1;
          for (int i = 0; i < exp_q.size(); i++)
            if (idx < 0 && exp_q[i].cyc == cyc && exp_q[i].kind == kd) idx = i;
          n_checks++;
          if (idx < 0) begin
            $display("FAIL unexpected_%s at cycle %0d: got %b, required 00", kname(kd), cyc, obs[kd]);
          end else begin
            if (exp_q[idx].mask !== obs[kd])
              $display("FAIL %s_mask at cycle %0d: got %b, required %b", kname(kd), cyc, obs[kd], exp_q[idx].mask);
            else
              n_pass++;
            exp_q.delete(idx);
          end
        end
      end
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].cyc <= cyc) begin
          n_checks++;
          $display("FAIL missed_%s at cycle %0d: got 00, required %b", kname(exp_q[i].kind), exp_q[i].cyc, exp_q[i].mask);
          exp_q.delete(i);
        end
      end
    end
  end

  task automatic wait_drain(input int budget);
    int b;
    b = budget;
    while (exp_q.size() != 0 && b > 0) begin
      @(negedge clk);
      b--;
    end
    repeat (3) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: got %0d pending events, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    int k;
    @(negedge clk);
    reset   = 1'b1;
    btn_raw = 2'b00;
    repeat (3) begin
      @(negedge clk);
      mon_en = 1'b1;
      n_checks++;
      if ({press_pulse, release_pulse, held, repeat_pulse, btn_state} !== '0)
        $display("FAIL reset_outputs: got %b, required 0",
                 {press_pulse, release_pulse, held, repeat_pulse, btn_state});
      else
        n_pass++;
    end
    reset = 1'b0;
    k = cyc + 1;
    push(k + LAT, 0, 2'b11);
    while (cyc < k + 9) @(negedge clk);
    btn_raw = 2'b11;
    push(cyc + 1 + LAT, 1, 2'b11);
    wait_drain(40);
  endtask

  task automatic test_clean_press();
    int k, rel;
    @(negedge clk);
    btn_raw[0] = 1'b0;
    k = cyc + 1;
    push(k + LAT, 0, 2'b01);
    push(k + 10 + LAT, 1, 2'b01);
    for (int t = 0; t < 22; t++) begin
      @(negedge clk);
      rel = cyc - k;
      if (rel == 6) begin
        n_checks++;
        if ({held[0], btn_state[1:0]} !== 3'b000)
          $display("FAIL pre_press_idle: got %b, required 000", {held[0], btn_state[1:0]});
        else n_pass++;
      end
      if (rel == 7) begin
        n_checks++;
        if ({held[0], btn_state[1:0]} !== 3'b101)
          $display("FAIL pressed_state: got %b, required 101", {held[0], btn_state[1:0]});
        else n_pass++;
      end
      if (rel == 8) begin
        n_checks++;
        if ({held[0], btn_state} !== 5'b1_0010)
          $display("FAIL held_state: got %b, required 10010", {held[0], btn_state});
        else n_pass++;
      end
      if (rel == 9) btn_raw[0] = 1'b1;
      if (rel == 16) begin
        n_checks++;
        if ({held[0], btn_state[1:0]} !== 3'b110)
          $display("FAIL last_held_cycle: got %b, required 110", {held[0], btn_state[1:0]});
        else n_pass++;
      end
      if (rel == 17) begin
        n_checks++;
        if ({held[0], btn_state[1:0]} !== 3'b011)
          $display("FAIL released_state: got %b, required 011", {held[0], btn_state[1:0]});
        else n_pass++;
      end
      if (rel == 18) begin
        n_checks++;
        if (btn_state[1:0] !== 2'd0)
          $display("FAIL back_to_idle: got %0d, required 0", btn_state[1:0]);
        else n_pass++;
      end
    end
    wait_drain(20);
  endtask

  task automatic test_glitch();
    int k;
    bit bad;
    for (int len = 3; len <= DEB; len++) begin
      @(negedge clk);
      btn_raw[0] = 1'b0;
      repeat (len) @(negedge clk);
      btn_raw[0] = 1'b1;
      bad = 1'b0;
      repeat (12) begin
        @(negedge clk);
        if (held[0] !== 1'b0 || btn_state[1:0] !== 2'd0) bad = 1'b1;
      end
      n_checks++;
      if (bad) $display("FAIL glitch_len%0d_state: got activity, required idle", len);
      else n_pass++;
      n_checks++;
      if (dut.g_ch[0].u_ch.cnt !== '0)
        $display("FAIL glitch_len%0d_counter: got %0d, required 0", len, dut.g_ch[0].u_ch.cnt);
      else n_pass++;
    end
    // One sample longer than the debounce window is accepted, and so is its release.
    @(negedge clk);
    btn_raw[0] = 1'b0;
    k = cyc + 1;
    push(k + LAT, 0, 2'b01);
    push(k + 5 + LAT, 1, 2'b01);
    repeat (5) @(negedge clk);
    btn_raw[0] = 1'b1;
    wait_drain(30);
  endtask

  task automatic test_autorepeat();
    int k, rel;
    @(negedge clk);
    btn_raw[0] = 1'b0;
    k = cyc + 1;
    push(k + LAT, 0, 2'b01);
`ifdef BTN_AUTOREPEAT_EN
    for (int n = RD; n <= 30; n += RP) push(k + LAT + n, 2, 2'b01);
`endif
    push(k + 31 + LAT, 1, 2'b01);
    for (int t = 0; t < 42; t++) begin
      @(negedge clk);
      rel = cyc - k;
      if (rel == 19) btn_raw[0] = 1'b1;
      if (rel == 21) btn_raw[0] = 1'b0;
      if (rel == 30) btn_raw[0] = 1'b1;
      if (rel == 24) begin
        n_checks++;
        if ({held[0], btn_state[1:0]} !== 3'b110)
          $display("FAIL bounce_in_held: got %b, required 110", {held[0], btn_state[1:0]});
        else n_pass++;
      end
    end
    wait_drain(20);
  endtask

  task automatic test_simultaneous();
    int k, rel;
    @(negedge clk);
    btn_raw = 2'b00;
    k = cyc + 1;
    push(k + LAT, 0, 2'b11);
    push(k + 10 + LAT, 1, 2'b11);
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      rel = cyc - k;
      if (rel == 7) begin
        n_checks++;
        if ({held, btn_state} !== 6'b11_0101)
          $display("FAIL simultaneous_state: got %b, required 110101", {held, btn_state});
        else n_pass++;
      end
      if (rel == 9) btn_raw = 2'b11;
    end
    wait_drain(30);
  endtask

  task automatic test_mid_reset();
    int k, j;
    @(negedge clk);
    btn_raw[0] = 1'b0;
    k = cyc + 1;
    push(k + LAT, 0, 2'b01);
    while (cyc < k + 9) @(negedge clk);
    n_checks++;
    if (btn_state[1:0] !== 2'd2)
      $display("FAIL mid_reset_pre_held: got %0d, required 2", btn_state[1:0]);
    else n_pass++;
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if ({held, release_pulse, btn_state} !== '0)
        $display("FAIL mid_reset_outputs: got %b, required 0", {held, release_pulse, btn_state});
      else n_pass++;
    end
    reset = 1'b0;
    j = cyc + 1;
    push(j + LAT, 0, 2'b01);
    while (cyc < j + 9) @(negedge clk);
    btn_raw[0] = 1'b1;
    push(cyc + 1 + LAT, 1, 2'b01);
    wait_drain(30);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_autorepeat();
    test_simultaneous();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
